// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding memory request feeding an in-order
// instruction queue, with redirect (flush) support and misaligned-target flagging.
module ifetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            misalign
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetchPc_q, fetchPc_d;
  logic [XLEN-1:0] reqPc_q, reqPc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic            misalign_q, misalign_d;

  logic [31:0]     dataMem_q [DEPTH];
  logic [XLEN-1:0] pcMem_q   [DEPTH];

  logic grant;
  logic push;
  logic pop;

  // A new request is only issued in IDLE, so the single outstanding request
  // always has a free queue slot reserved for its response.
  always_comb begin
    state_d    = state_q;
    fetchPc_d  = fetchPc_q;
    reqPc_d    = reqPc_q;
    count_d    = count_q;
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    misalign_d = 1'b0;

    imem_req   = !rst && (state_q == IDLE) && (count_q < CW'(DEPTH)) && !redir_valid;
    inst_valid = !rst && (count_q != '0);
    grant      = imem_req && imem_gnt;
    push       = (state_q == WAIT) && imem_rvalid && !redir_valid;
    pop        = inst_valid && inst_ready && !redir_valid;

    if (grant) begin
      reqPc_d   = fetchPc_q;
      fetchPc_d = fetchPc_q + XLEN'(4);
    end

    case (state_q)
      IDLE: begin
        if (grant) state_d = WAIT;
      end
      WAIT: begin
        if (redir_valid) begin
          state_d = imem_rvalid ? IDLE : DISCARD;
        end else if (imem_rvalid) begin
          state_d = IDLE;
        end
      end
      DISCARD: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (push) wrPtr_d = wrPtr_q + PW'(1);
    if (pop)  rdPtr_d = rdPtr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    // Redirect overrides everything: flush the queue and restart at the aligned target.
    if (redir_valid) begin
      fetchPc_d  = {redir_pc[XLEN-1:2], 2'b00};
      misalign_d = |redir_pc[1:0];
      count_d    = '0;
      rdPtr_d    = '0;
      wrPtr_d    = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= IDLE;
      fetchPc_q  <= RESET_PC;
      reqPc_q    <= '0;
      count_q    <= '0;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetchPc_q  <= fetchPc_d;
      reqPc_q    <= reqPc_d;
      count_q    <= count_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      misalign_q <= misalign_d;
    end
  end

  // Queue storage needs no reset; count_q alone decides which entries are live.
  always_ff @(posedge CLK) begin
    if (push) begin
      dataMem_q[wrPtr_q] <= imem_rdata;
      pcMem_q[wrPtr_q]   <= reqPc_q;
    end
  end

  assign imem_addr = fetchPc_q;
  assign inst_data = dataMem_q[rdPtr_q];
  assign inst_pc   = pcMem_q[rdPtr_q];
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a streaming/backpressure vector table plus
// hand-written redirect, wrap and reset sequences against a simple memory responder.
module tb_ifetch_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            CLK = 1'b0;
  logic            rst = 1'b1;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt = 1'b0;
  logic            imem_rvalid = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic            redir_valid = 1'b0;
  logic [XLEN-1:0] redir_pc = '0;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            misalign;

  int passCount  = 0;
  int totalCount = 0;

  ifetch_unit #(
    .XLEN    (XLEN),
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_data  (inst_data),
    .inst_pc    (inst_pc),
    .misalign   (misalign)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_A5A5;
  endfunction

  // Memory responder: a grant seen before an edge returns data 'lat' cycles later.
  int          lat = 1;
  logic        gSeen = 1'b0;
  logic [31:0] gAddr = '0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pAddr = '0;

  always @(negedge CLK) begin
    gSeen = imem_req && imem_gnt;
    gAddr = imem_addr;
  end

  always @(posedge CLK) begin
    #1;
    if (gSeen) begin
      pend  = 1'b1;
      cnt   = lat - 1;
      pAddr = gAddr;
    end
    imem_rvalid = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memWord(pAddr);
        pend        = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end
  end

  typedef struct {
    logic        gnt;
    logic        rdy;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs[22];

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic g, input logic rd,
                               input logic rv, input logic [31:0] rp);
    rst         = r;
    imem_gnt    = g;
    inst_ready  = rd;
    redir_valid = rv;
    redir_pc    = rp;
  endtask

  task automatic checkOutput(input string name, input logic eReq, input logic [31:0] eAddr,
                             input logic eValid, input logic [31:0] ePc, input logic eMis);
    logic ok;
    logic [31:0] eData;
    eData = memWord(ePc);
    ok = (imem_req === eReq) && (imem_addr === eAddr) && (inst_valid === eValid) &&
         (misalign === eMis);
    if (eValid) ok = ok && (inst_pc === ePc) && (inst_data === eData);
    totalCount++;
    if (ok) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got req=%0b addr=%h valid=%0b pc=%h data=%h mis=%0b, want req=%0b addr=%h valid=%0b pc=%h data=%h mis=%0b",
               name, imem_req, imem_addr, inst_valid, inst_pc, inst_data, misalign,
               eReq, eAddr, eValid, ePc, eData, eMis);
    end
  endtask

  task automatic stepCheck(input string name, input logic r, input logic g, input logic rd,
                           input logic rv, input logic [31:0] rp,
                           input logic eReq, input logic [31:0] eAddr,
                           input logic eValid, input logic [31:0] ePc, input logic eMis);
    applyStimulus(r, g, rd, rv, rp);
    #1;
    checkOutput(name, eReq, eAddr, eValid, ePc, eMis);
    nextCycle();
  endtask

  // Leaves the caller just after the last reset edge, ready to drive the first released cycle.
  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    nextCycle();
    #1;
    checkOutput("reset_hold", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    nextCycle();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h04, 1'b0, 32'h00};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h08, 1'b0, 32'h00};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0C, 1'b0, 32'h00};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 32'h00};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h0C};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 32'h0C};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 32'h1C, 1'b1, 32'h0C};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h14};
    vecs[19] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h18};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 32'h24, 1'b1, 32'h1C};
    vecs[21] = '{1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h20};

    // Streaming, then backpressure until the queue fills, then drain while fetching.
    lat = 1;
    doReset();
    for (int i = 0; i < 22; i++) begin
      stepCheck($sformatf("stream[%0d]", i), 1'b0, vecs[i].gnt, vecs[i].rdy, 1'b0, 32'h0,
                vecs[i].expReq, vecs[i].expAddr, vecs[i].expValid, vecs[i].expPc, 1'b0);
    end

    // Redirect while waiting; the stale response arrives in DISCARD and is dropped.
    doReset();
    lat = 3;
    stepCheck("redir_wait_c0",   1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h0, 1'b0);
    stepCheck("redir_wait_c1",   1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h004, 1'b0, 32'h0, 1'b0);
    stepCheck("discard_wait",    1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0, 1'b0);
    lat = 1;
    stepCheck("discard_stale",   1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0, 1'b0);
    stepCheck("refetch_req",     1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    stepCheck("refetch_wait",    1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h0, 1'b0);
    stepCheck("refetch_head",    1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100, 1'b0);

    // Misaligned redirect, stable address without grant, PC wrap, redirect with pop and with rvalid.
    doReset();
    lat = 1;
    stepCheck("redir_idle_noreq", 1'b0, 1'b1, 1'b1, 1'b1, 32'h102,       1'b0, 32'h000,       1'b0, 32'h0, 1'b0);
    stepCheck("misalign_pulse",   1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h100,       1'b0, 32'h0, 1'b1);
    stepCheck("misalign_clear",   1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h100,       1'b0, 32'h0, 1'b0);
    stepCheck("redir_to_top",     1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h100,       1'b0, 32'h0, 1'b0);
    stepCheck("top_req",          1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    stepCheck("wrap_addr",        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h000,       1'b0, 32'h0, 1'b0);
    stepCheck("top_head_redir",   1'b0, 1'b1, 1'b1, 1'b1, 32'h200,       1'b0, 32'h000,       1'b1, 32'hFFFF_FFFC, 1'b0);
    stepCheck("pop_redir_flush",  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h200,       1'b0, 32'h0, 1'b0);
    stepCheck("redir_rvalid_c",   1'b0, 1'b1, 1'b1, 1'b1, 32'h300,       1'b0, 32'h204,       1'b0, 32'h0, 1'b0);
    stepCheck("redir_rvalid_drop",1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h300,       1'b0, 32'h0, 1'b0);
    stepCheck("redir300_wait",    1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h304,       1'b0, 32'h0, 1'b0);
    stepCheck("redir300_head",    1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h304,       1'b1, 32'h300, 1'b0);

    // Reset while the fourth request is outstanding; its late response must be ignored.
    doReset();
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      nextCycle();
    end
    lat = 4;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    nextCycle();
    stepCheck("fill3_req",        1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b1, 32'h0, 1'b0);
    stepCheck("rst_in_wait",      1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h10, 1'b0, 32'h0, 1'b0);
    stepCheck("rst_wait_full",    1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00, 1'b0, 32'h0, 1'b0);
    stepCheck("rst_release",      1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, 32'h0, 1'b0);
    stepCheck("late_rvalid",      1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, 32'h0, 1'b0);
    lat = 1;
    stepCheck("late_rvalid_ignored", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, 32'h0, 1'b0);
    stepCheck("post_rst_wait",    1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h04, 1'b0, 32'h0, 1'b0);
    stepCheck("post_rst_head",    1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h04, 1'b1, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
